// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - two-requester round-robin arbiter in front of an I2C master
// Optional wait-state abort counter enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [1:0]  req_write_i,
    input  logic [1:0]  req_read_i,
    input  logic [15:0] req_slave_addr_i,
    input  logic [15:0] req_command_byte_i,
    input  logic [15:0] req_din_i,
    input  logic [15:0] req_num_bytes_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic [1:0]  error_o,
    output logic [1:0]  data_out_valid_o,
    output logic [7:0]  data_out_o,
    output logic        i2c_write_o,
    output logic        i2c_read_o,
    output logic [7:0]  i2c_slave_addr_o,
    output logic [7:0]  i2c_command_byte_o,
    output logic [7:0]  i2c_din_o,
    output logic [7:0]  i2c_num_bytes_o,
    input  logic        i2c_busy_i,
    input  logic        i2c_rxak_i,
    input  logic        i2c_arb_lost_i,
    input  logic        i2c_data_out_valid_i,
    input  logic [7:0]  i2c_data_out_i
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_END, DONE} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  din_q, din_d;
    logic [7:0]  num_q, num_d;
    logic [1:0]  req;
    logic        win;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        expired;
    assign expired = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    logic        unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    assign req = req_write_i | req_read_i;
    // On contention the requester that was not served last wins.
    assign win = (req == 2'b11) ? ~last_q : req[1];

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        err_d      = err_q;
        is_write_d = is_write_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        cmd_d      = cmd_q;
        din_d      = din_q;
        num_d      = num_q;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        if ((state_q == ISSUE || state_q == WAIT_START || state_q == WAIT_END) &&
            (i2c_rxak_i || i2c_arb_lost_i)) begin
            err_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (|req && !i2c_busy_i) begin
                    gnt_d      = win ? 2'b10 : 2'b01;
                    is_write_d = req_write_i[win];
                    addr_d     = req_slave_addr_i[{win, 3'b000} +: 8];
                    cmd_d      = req_command_byte_i[{win, 3'b000} +: 8];
                    din_d      = req_din_i[{win, 3'b000} +: 8];
                    num_d      = req_num_bytes_i[{win, 3'b000} +: 8];
                    err_d      = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_START;
`ifdef I2C_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_START: begin
                if (i2c_busy_i) begin
                    state_d = WAIT_END;
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
            end
            WAIT_END: begin
                if (!i2c_busy_i) begin
                    state_d = DONE;
`ifdef I2C_ARB_TIMEOUT_EN
                end else if (expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
            end
            DONE: begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            err_q      <= 1'b0;
            is_write_q <= 1'b0;
            gnt_q      <= 2'b00;
            addr_q     <= '0;
            cmd_q      <= '0;
            din_q      <= '0;
            num_q      <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            err_q      <= err_d;
            is_write_q <= is_write_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            din_q      <= din_d;
            num_q      <= num_d;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign gnt_o              = gnt_q;
    assign done_o             = (state_q == DONE) ? gnt_q : 2'b00;
    assign error_o            = (state_q == DONE && err_q) ? gnt_q : 2'b00;
    assign data_out_valid_o   = i2c_data_out_valid_i ? gnt_q : 2'b00;
    assign data_out_o         = i2c_data_out_i;
    assign i2c_write_o        = (state_q == ISSUE) && is_write_q;
    assign i2c_read_o         = (state_q == ISSUE) && !is_write_q;
    assign i2c_slave_addr_o   = addr_q;
    assign i2c_command_byte_o = cmd_q;
    assign i2c_din_o          = din_q;
    assign i2c_num_bytes_o    = num_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - randomized self-checking bench for i2c_arbiter
module tb_i2c_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [1:0]  req_write_i, req_read_i;
    logic [15:0] req_slave_addr_i, req_command_byte_i, req_din_i, req_num_bytes_i;
    logic [1:0]  gnt_o, done_o, error_o, data_out_valid_o;
    logic [7:0]  data_out_o;
    logic        i2c_write_o, i2c_read_o;
    logic [7:0]  i2c_slave_addr_o, i2c_command_byte_o, i2c_din_o, i2c_num_bytes_o;
    logic        i2c_busy_i, i2c_rxak_i, i2c_arb_lost_i, i2c_data_out_valid_i;
    logic [7:0]  i2c_data_out_i;

    int n_tests = 0;
    int n_fail  = 0;
    bit last_m;

    always #5 clk = ~clk;

    i2c_arbiter #(.TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .reset_i(reset_i),
        .req_write_i(req_write_i), .req_read_i(req_read_i),
        .req_slave_addr_i(req_slave_addr_i), .req_command_byte_i(req_command_byte_i),
        .req_din_i(req_din_i), .req_num_bytes_i(req_num_bytes_i),
        .gnt_o(gnt_o), .done_o(done_o), .error_o(error_o),
        .data_out_valid_o(data_out_valid_o), .data_out_o(data_out_o),
        .i2c_write_o(i2c_write_o), .i2c_read_o(i2c_read_o),
        .i2c_slave_addr_o(i2c_slave_addr_o), .i2c_command_byte_o(i2c_command_byte_o),
        .i2c_din_o(i2c_din_o), .i2c_num_bytes_o(i2c_num_bytes_o),
        .i2c_busy_i(i2c_busy_i), .i2c_rxak_i(i2c_rxak_i), .i2c_arb_lost_i(i2c_arb_lost_i),
        .i2c_data_out_valid_i(i2c_data_out_valid_i), .i2c_data_out_i(i2c_data_out_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int predict(input logic [1:0] act);
        if (act == 2'b11) return last_m ? 0 : 1;
        return act[1] ? 1 : 0;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, gnt_o, 2'b00);
        check({tag, "_done"}, done_o, 2'b00);
        check({tag, "_err"}, error_o, 2'b00);
        check({tag, "_start"}, {i2c_write_o, i2c_read_o}, 2'b00);
        check({tag, "_dv"}, data_out_valid_o, 2'b00);
        check({tag, "_fields"}, {i2c_slave_addr_o, i2c_command_byte_o, i2c_din_o, i2c_num_bytes_o}, 32'h0);
    endtask

    // Waits up to 5 cycles for a grant; returns whether one appeared and how late.
    task automatic wait_grant(output bit got, output int lat);
        got = 0;
        lat = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (gnt_o != 2'b00) begin
                got = 1;
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_round(input logic [1:0] wr, input logic [1:0] rd, input int err_kind,
                            input int busy_len, input logic [15:0] addr, input bit directed_rd);
        int          w, lat, d, wp, rp;
        bit          got;
        logic [1:0]  oh;
        logic        exp_wr, v;
        logic [7:0]  dat;
        logic [31:0] e_fields;
        w = predict(wr | rd);
        oh = 2'b01 << w;
        exp_wr = wr[w];
        req_slave_addr_i   = addr;
        req_command_byte_i = 16'($urandom);
        req_din_i          = 16'($urandom);
        req_num_bytes_i    = 16'($urandom);
        e_fields = {addr[8*w +: 8], req_command_byte_i[8*w +: 8],
                    req_din_i[8*w +: 8], req_num_bytes_i[8*w +: 8]};
        req_write_i = wr;
        req_read_i  = rd;
        wait_grant(got, lat);
        check("grant_seen", got, 1);
        if (!got) begin
            req_write_i = 0;
            req_read_i  = 0;
            return;
        end
        check("grant_latency", lat, 0);
        check("gnt", gnt_o, oh);
        check("fields_at_grant", {i2c_slave_addr_o, i2c_command_byte_o, i2c_din_o, i2c_num_bytes_o}, e_fields);
        wp = i2c_write_o;
        rp = i2c_read_o;
        req_slave_addr_i   = 16'($urandom);
        req_command_byte_i = 16'($urandom);
        req_din_i          = 16'($urandom);
        req_num_bytes_i    = 16'($urandom);
        d = $urandom_range(1, 3);
        for (int i = 0; i < d; i++) begin
            tick();
            wp += i2c_write_o;
            rp += i2c_read_o;
        end
        i2c_busy_i = 1;
        for (int i = 0; i < busy_len; i++) begin
            tick();
            wp += i2c_write_o;
            rp += i2c_read_o;
            v   = directed_rd ? (i < 4) : 1'($urandom_range(0, 1));
            dat = directed_rd ? 8'((i + 1) * 17) : 8'($urandom);
            i2c_data_out_valid_i = v;
            i2c_data_out_i       = dat;
            i2c_rxak_i     = (err_kind == 1) && (i == busy_len / 2);
            i2c_arb_lost_i = (err_kind == 2) && (i == busy_len / 2);
            #1;
            check("data_valid_route", data_out_valid_o, v ? oh : 2'b00);
            check("data_pass", data_out_o, dat);
            check("no_early_done", {done_o, error_o}, 4'h0);
            check("gnt_hold", gnt_o, oh);
        end
        tick();
        i2c_data_out_valid_i = 0;
        i2c_rxak_i     = 0;
        i2c_arb_lost_i = 0;
        i2c_busy_i     = 0;
        tick();
        check("done", done_o, oh);
        check("error", error_o, (err_kind != 0) ? oh : 2'b00);
        check("write_pulses", wp, exp_wr ? 1 : 0);
        check("read_pulses", rp, exp_wr ? 0 : 1);
        check("fields_held", {i2c_slave_addr_o, i2c_command_byte_o, i2c_din_o, i2c_num_bytes_o}, e_fields);
        req_write_i = 0;
        req_read_i  = 0;
        last_m = (w == 1);
        tick();
        check("after_done", {gnt_o, done_o, error_o}, 6'h0);
    endtask

    task automatic reset_mid_op();
        bit got;
        int lat;
        req_write_i = 2'b10;
        wait_grant(got, lat);
        check("rst_grant_seen", got, 1);
        i2c_busy_i = 1;
        tick();
        tick();
        tick();
        i2c_data_out_valid_i = 1;
        req_read_i  = 2'b11;
        reset_i = 0;
        #1;
        check_idle_outputs("rst_mid");
        i2c_busy_i = 0;
        tick();
        tick();
        check("rst_hold_gnt", gnt_o, 2'b00);
        i2c_data_out_valid_i = 0;
        req_write_i = 0;
        req_read_i  = 0;
        reset_i = 1;
        last_m = 1;
    endtask

    task automatic timeout_test();
        bit got, seen;
        int lat, w, k;
        logic [1:0] oh;
        w = predict(2'b01);
        oh = 2'b01 << w;
        req_write_i = 2'b01;
        wait_grant(got, lat);
        check("to_grant_seen", got, 1);
`ifdef I2C_ARB_TIMEOUT_EN
        seen = 0;
        for (k = 1; k <= 40; k++) begin
            tick();
            if (done_o != 2'b00) begin
                seen = 1;
                break;
            end
        end
        check("to_done_seen", seen, 1);
        check("to_latency", k, 21);
        check("to_done", done_o, oh);
        check("to_error", error_o, oh);
`else
        seen = 0;
        for (k = 0; k < 1000; k++) begin
            tick();
            if (done_o != 2'b00) seen = 1;
        end
        check("no_timeout", seen, 0);
        i2c_busy_i = 1;
        tick();
        tick();
        i2c_busy_i = 0;
        tick();
        check("late_done", done_o, oh);
        check("late_error", error_o, 2'b00);
`endif
        req_write_i = 0;
        last_m = (w == 1);
        tick();
        check("to_after", {gnt_o, done_o}, 4'h0);
    endtask

    initial begin
        logic [1:0] wr, rd;
        reset_i = 0;
        req_write_i = 0; req_read_i = 0;
        req_slave_addr_i = 0; req_command_byte_i = 0; req_din_i = 0; req_num_bytes_i = 0;
        i2c_busy_i = 0; i2c_rxak_i = 0; i2c_arb_lost_i = 0;
        i2c_data_out_valid_i = 0; i2c_data_out_i = 0;
        last_m = 1;
        tick();
        tick();
        check_idle_outputs("reset");
        reset_i = 1;

        do_round(2'b00, 2'b11, 0, 4, 16'h5A21, 0);
        do_round(2'b00, 2'b11, 0, 4, 16'h5A21, 0);
        do_round(2'b01, 2'b00, 0, 10, 16'h003A, 0);
        do_round(2'b00, 2'b10, 0, 6, 16'h7700, 1);
        do_round(2'b10, 2'b00, 1, 5, 16'h1234, 0);
        do_round(2'b10, 2'b00, 0, 5, 16'h1234, 0);
        do_round(2'b01, 2'b01, 2, 3, 16'h4455, 0);
        reset_mid_op();
        do_round(2'b00, 2'b11, 0, 3, 16'h6622, 0);
        timeout_test();
        for (int n = 0; n < 40; n++) begin
            do begin
                wr = 2'($urandom);
                rd = 2'($urandom);
            end while ((wr | rd) == 2'b00);
            do_round(wr, rd, $urandom_range(0, 2), $urandom_range(1, 8), 16'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
